uart_rx_controller: RTL
=======================

Name: uart_rx_controller

Overview:
Receive-side frame FSM for the UART link, the counterpart of the TX transmission controller. It oversamples the serial RX_IN line by Prescale and detects the start bit, rejecting start glitches. It samples DATA_WIDTH data bits LSB first, checks optional parity and the stop bit, and presents each correct frame on P_DATA with a one-cycle Data_Valid pulse. It sits between the RX_IN pin synchronizer and the system data-sync/register block.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the Prescale input and edge counter

Ports:
CLK  in  1  system clock; one clock domain
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  serial line; already synchronized upstream; idles high
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
P_DATA  out  DATA_WIDTH  last correctly received data word
Data_Valid  out  1  one-cycle pulse when P_DATA is updated
Par_Err  out  1  parity error flag for the current/last frame
Stop_Err  out  1  stop-bit error flag for the current/last frame
Busy  out  1  high while not in IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; shift register 0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..Prescale-1 within each bit and wraps to 0 at the end of each bit. bit_cnt counts data bits 0..DATA_WIDTH-1.
- IDLE: RX_IN==0 -> START with edge_cnt=0.
  - On this transition, latch PAR_EN, PAR_TYP and Prescale. Changes to these inputs mid-frame are ignored.
  - On this transition, clear Par_Err and Stop_Err.
- Sample point: the value of RX_IN when edge_cnt == Prescale/2.
- START:
  - If the sample is 1, treat it as a glitch: return to IDLE at the next edge. No flags change and no Data_Valid is produced.
  - Otherwise go to DATA at the end of the bit (edge_cnt == Prescale-1).
- DATA:
  - Shift the sample into shift_reg MSB side, LSB first.
  - At the end of the bit with bit_cnt == DATA_WIDTH-1, go to PARITY if the latched PAR_EN is 1, else go to STOP.
- PARITY:
  - expected = XOR of the data bits, XORed with PAR_TYP.
  - If sample != expected, set Par_Err=1.
  - At the end of the bit, go to STOP.
- STOP:
  - If the sample is 0, set Stop_Err=1.
  - At the end of the bit, go to IDLE.
  - At that same edge, if the stop sample was 1 and Par_Err==0: load P_DATA <= shift_reg and pulse Data_Valid for exactly 1 cycle.
  - Otherwise P_DATA holds its old value and there is no pulse.
- Latency: Data_Valid rises on the clock edge that ends the stop bit.
- Back-to-back frames: a start bit immediately following a stop bit is detected from IDLE one cycle later. This is within the tolerance of every legal Prescale.
- Busy is 1 in every state except IDLE.
- Error flags are sticky until the next start detection.
- Illegal Prescale: behaviour undefined; the bench must not drive it.
- Asynchronous reset mid-frame: immediate return to IDLE with all outputs 0. A partial frame is never delivered.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each bit value is the 2-of-3 majority of RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The decision is available at Prescale/2+1, and all state decisions above use this voted value.
- Undefined: a single sample at Prescale/2 is used, and no voting logic is present.

Decomposition:
- Shared package/header uart_pkg:
  - RX state encodings.
  - Prescale legal constants (8/16/32).
  - Parity type constants (EVEN=0, ODD=1).
  - DATA_WIDTH default.
- One sub-module, uart_rx_edge_bit_counter:
  - Holds edge_cnt and bit_cnt.
  - Provides bit_end and sample_point strobes driven by the FSM enable.
  - FSM, sampler, parity checker and output registers stay in uart_rx_controller.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 -> P_DATA=0xA5; Data_Valid high exactly 1 cycle at the end of the stop bit; Par_Err=0, Stop_Err=0.
- Prescale=16, odd parity, 0x5A sent with a wrong parity bit -> Par_Err=1, no Data_Valid, P_DATA unchanged.
- Prescale=8, RX_IN low for 3 cycles then high -> glitch rejected: return to IDLE, Busy drops, no flags, no Data_Valid.
- Prescale=32, PAR_EN=0, 0x3C then 0xC3 back-to-back with stop bit 0 on the second -> first delivers 0x3C; second gives Stop_Err=1, no Data_Valid, P_DATA stays 0x3C.
- RST low during DATA bit 4 -> all outputs 0 immediately; the next clean frame 0x81 is received correctly.
- With UART_RX_MAJORITY_VOTE_EN, Prescale=16, 1-cycle inverted glitch at edge 8 of data bit 2 in 0xFF -> P_DATA=0xFF. Without the macro, the same stimulus gives P_DATA=0xFB.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART receive types, parity codes and prescale constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter.sv
// ============================================================================
// uart_rx_edge_bit_counter : per-bit oversampling edge counter and data-bit
// counter with bit-end / sample-point strobes. Macro: UART_RX_MAJORITY_VOTE_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_edge_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en_i,
  input  logic                  data_en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_end_o,
  output logic                  sample_point_o,
`ifdef UART_RX_MAJORITY_VOTE_EN
  output logic                  vote_early_o,
  output logic                  vote_mid_o,
`endif
  output logic                  last_bit_o
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);
  localparam logic [BCW-1:0]        ONE_B    = BCW'(1);
  localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] half_w;

  assign half_w     = prescale_i >> 1;
  assign bit_end_o  = en_i && (edge_cnt_q == (prescale_i - ONE_P));
  assign last_bit_o = (bit_cnt_q == LAST_BIT);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one edge after mid-bit, once all three votes are in.
  assign vote_early_o   = en_i && (edge_cnt_q == (half_w - ONE_P));
  assign vote_mid_o     = en_i && (edge_cnt_q == half_w);
  assign sample_point_o = en_i && (edge_cnt_q == (half_w + ONE_P));
`else
  assign sample_point_o = en_i && (edge_cnt_q == half_w);
`endif

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!en_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_end_o) begin
      edge_cnt_d = '0;
      if (data_en_i) begin
        bit_cnt_d = last_bit_o ? '0 : (bit_cnt_q + ONE_B);
      end
    end else begin
      edge_cnt_d = edge_cnt_q + ONE_P;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_controller.sv
// ============================================================================
// uart_rx_controller : UART receive frame FSM (start/data/parity/stop) with
// registered outputs. Macro: UART_RX_MAJORITY_VOTE_EN (3-sample bit voting)
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err,
  output logic                  Busy
);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  par_typ_e              par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  busy_q, busy_d;

  logic cnt_en_w, bit_end_w, sample_point_w, last_bit_w, sample_w;

  assign cnt_en_w = (state_q != ST_IDLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_early_w, vote_mid_w;
  logic v_early_q, v_mid_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_early_q <= 1'b0;
      v_mid_q   <= 1'b0;
    end else begin
      if (vote_early_w) v_early_q <= RX_IN;
      if (vote_mid_w)   v_mid_q   <= RX_IN;
    end
  end

  assign sample_w = (v_early_q & v_mid_q) | (v_early_q & RX_IN) | (v_mid_q & RX_IN);
`else
  assign sample_w = RX_IN;
`endif

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .CLK            (CLK),
    .RST            (RST),
    .en_i           (cnt_en_w),
    .data_en_i      (state_q == ST_DATA),
    .prescale_i     (presc_q),
    .bit_end_o      (bit_end_w),
    .sample_point_o (sample_point_w),
`ifdef UART_RX_MAJORITY_VOTE_EN
    .vote_early_o   (vote_early_w),
    .vote_mid_o     (vote_mid_w),
`endif
    .last_bit_o     (last_bit_w)
  );

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    case (state_q)
      ST_IDLE: begin
        // An illegal prescale never starts a frame, so the counter cannot run away.
        if (!RX_IN && prescale_legal(32'(Prescale))) begin
          state_d    = ST_START;
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = par_typ_e'(PAR_TYP);
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (sample_point_w && sample_w) state_d = ST_IDLE;
        else if (bit_end_w)             state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample_point_w) shift_d = {sample_w, shift_q[DATA_WIDTH-1:1]};
        if (bit_end_w && last_bit_w) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (sample_point_w && (sample_w != ((^shift_q) ^ (par_typ_q == PAR_ODD))))
          par_err_d = 1'b1;
        if (bit_end_w) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_point_w && !sample_w) stop_err_d = 1'b1;
        if (bit_end_w) begin
          state_d = ST_IDLE;
          // Stop_Err still clear here means the stop sample was a 1.
          if (!stop_err_q && !par_err_q) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shift_q    <= '0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      busy_q     <= busy_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = par_err_q;
  assign Stop_Err   = stop_err_q;
  assign Busy       = busy_q;

endmodule

`default_nettype wire
